l1_dcache_wb: RTL and testbench

Parametrised direct-mapped, write-back, write-allocate L1 data cache with per-block valid and dirty bits. It sits between the core's data port and the L2/memory side, and replaces the fixed-size data L1. Its miss engine uses a req/ack handshake and moves one word per beat, running writeback of the victim first and then refill. A flush command writes back every dirty block.

---
 rtl/l1_cache_pkg.sv | 41 ++++
 rtl/l1_tag_store.sv | 52 +++++
 rtl/l1_dcache_wb.sv | 213 +++++++++++++++++++++
 tb/tb_l1_dcache_wb.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/l1_cache_pkg.sv
// Shared types and helpers for the write-back L1 data cache: FSM state
// encoding, derived field widths and word-address field extraction.
package l1_cache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRBACK,
        ST_REFILL,
        ST_FLUSH
    } state_t;

    function automatic int off_width(input int block_words);
        return $clog2(block_words);
    endfunction

    function automatic int idx_width(input int num_blocks);
        return $clog2(num_blocks);
    endfunction

    function automatic int tag_width(input int addr_width, input int block_words,
                                     input int num_blocks);
        return addr_width - $clog2(num_blocks) - $clog2(block_words);
    endfunction

    // Field extractors work on a 32-bit view; callers size-cast the result.
    function automatic logic [31:0] addr_off(input logic [31:0] addr, input int off_w);
        return addr & ((32'd1 << off_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_idx(input logic [31:0] addr, input int off_w,
                                             input int idx_w);
        return (addr >> off_w) & ((32'd1 << idx_w) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int off_w,
                                             input int idx_w);
        return addr >> (off_w + idx_w);
    endfunction

endpackage

// File: rtl/l1_tag_store.sv
// Per-block valid, dirty and tag storage for the direct-mapped L1 data cache.
// Valid/dirty clear synchronously on reset; tags are left uninitialised.
module l1_tag_store
    import l1_cache_pkg::*;
#(
    parameter int IDX_W = 9,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic             o_valid,
    output logic             o_dirty,
    output logic [TAG_W-1:0] o_tag,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic             i_tag_we,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic             i_set_valid,
    input  logic             i_set_dirty,
    input  logic             i_clr_dirty
);

    localparam int NUM = 1 << IDX_W;

    logic [NUM-1:0]   r_valid;
    logic [NUM-1:0]   r_dirty;
    logic [TAG_W-1:0] r_tag [NUM];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (i_set_valid)
                r_valid[i_wr_idx] <= 1'b1;
            if (i_set_dirty)
                r_dirty[i_wr_idx] <= 1'b1;
            else if (i_clr_dirty)
                r_dirty[i_wr_idx] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_tag_we)
            r_tag[i_wr_idx] <= i_wr_tag;
    end

    assign o_valid = r_valid[i_rd_idx];
    assign o_dirty = r_dirty[i_rd_idx];
    assign o_tag   = r_tag[i_rd_idx];

endmodule

// File: rtl/l1_dcache_wb.sv
// Direct-mapped write-back, write-allocate L1 data cache with a one-word-per-beat
// req/ack miss engine (victim writeback, then refill) and a flush-all-dirty scan.
//
// state   | meaning
// IDLE    | waiting for flush_req or cpu_req
// LOOKUP  | tag compare; hits complete here
// WRBACK  | writing the victim (miss) or scanned block (flush) to memory
// REFILL  | fetching the requested block from offset 0
// FLUSH   | scanning blocks for valid+dirty
module l1_dcache_wb
    import l1_cache_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int BLOCK_WORDS = 8,
    parameter int NUM_BLOCKS  = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ready,
    input  logic                  flush_req,
    output logic                  flush_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack
);

    localparam int OFF_W = off_width(BLOCK_WORDS);
    localparam int IDX_W = idx_width(NUM_BLOCKS);
    localparam int TAG_W = tag_width(ADDR_WIDTH, BLOCK_WORDS, NUM_BLOCKS);
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(BLOCK_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);

    state_t                  r_state, w_state_nxt;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [OFF_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_ptr;
    logic                    r_flushing;
    logic [DATA_WIDTH-1:0]   r_data [NUM_BLOCKS*BLOCK_WORDS];

    logic [TAG_W-1:0]        w_req_tag;
    logic [IDX_W-1:0]        w_req_idx;
    logic [OFF_W-1:0]        w_req_off;
    logic [IDX_W-1:0]        w_idx;
    logic                    w_valid, w_dirty, w_hit;
    logic [TAG_W-1:0]        w_tag_rd;
    logic                    w_tag_we, w_set_valid, w_set_dirty, w_clr_dirty;
    logic                    w_data_we;
    logic [IDX_W+OFF_W-1:0]  w_data_waddr;
    logic [DATA_WIDTH-1:0]   w_data_wval;
    logic                    w_ptr_inc;
    logic [DATA_WIDTH-1:0]   w_rd_word, w_wb_word;

    assign w_req_tag = TAG_W'(addr_tag(32'(r_addr), OFF_W, IDX_W));
    assign w_req_idx = IDX_W'(addr_idx(32'(r_addr), OFF_W, IDX_W));
    assign w_req_off = OFF_W'(addr_off(32'(r_addr), OFF_W));
    // During a flush the scan pointer selects the block; otherwise the request does.
    assign w_idx     = r_flushing ? r_ptr : w_req_idx;
    assign w_hit     = w_valid && (w_tag_rd == w_req_tag);
    assign w_rd_word = r_data[{w_req_idx, w_req_off}];
    assign w_wb_word = r_data[{w_idx, r_cnt}];

    l1_tag_store #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tags (
        .clk         (clk),
        .reset       (reset),
        .i_rd_idx    (w_idx),
        .o_valid     (w_valid),
        .o_dirty     (w_dirty),
        .o_tag       (w_tag_rd),
        .i_wr_idx    (w_idx),
        .i_tag_we    (w_tag_we),
        .i_wr_tag    (w_req_tag),
        .i_set_valid (w_set_valid),
        .i_set_dirty (w_set_dirty),
        .i_clr_dirty (w_clr_dirty)
    );

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        cpu_ready    = 1'b0;
        cpu_rdata    = '0;
        flush_done   = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        w_tag_we     = 1'b0;
        w_set_valid  = 1'b0;
        w_set_dirty  = 1'b0;
        w_clr_dirty  = 1'b0;
        w_data_we    = 1'b0;
        w_data_waddr = {w_req_idx, w_req_off};
        w_data_wval  = r_wdata;
        w_ptr_inc    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (flush_req)
                    w_state_nxt = ST_FLUSH;
                else if (cpu_req)
                    w_state_nxt = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                if (w_hit) begin
                    cpu_ready   = 1'b1;
                    cpu_rdata   = w_rd_word;
                    w_data_we   = r_we;
                    w_set_dirty = r_we;
                    w_state_nxt = ST_IDLE;
                end else if (w_valid && w_dirty) begin
                    w_state_nxt = ST_WRBACK;
                end else begin
                    w_state_nxt = ST_REFILL;
                end
            end
            ST_WRBACK: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {w_tag_rd, w_idx, r_cnt};
                mem_wdata = w_wb_word;
                if (mem_ack && r_cnt == LAST_OFF) begin
                    w_clr_dirty = 1'b1;
                    if (!r_flushing) begin
                        w_state_nxt = ST_REFILL;
                    end else if (r_ptr == LAST_IDX) begin
                        flush_done  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ptr_inc   = 1'b1;
                        w_state_nxt = ST_FLUSH;
                    end
                end
            end
            ST_REFILL: begin
                mem_req  = 1'b1;
                mem_addr = {w_req_tag, w_req_idx, r_cnt};
                if (mem_ack) begin
                    w_data_we    = 1'b1;
                    w_data_waddr = {w_req_idx, r_cnt};
                    w_data_wval  = mem_rdata;
                    if (r_cnt == LAST_OFF) begin
                        w_tag_we    = 1'b1;
                        w_set_valid = 1'b1;
                        w_clr_dirty = 1'b1;
                        w_state_nxt = ST_LOOKUP;
                    end
                end
            end
            ST_FLUSH: begin
                if (w_valid && w_dirty) begin
                    w_state_nxt = ST_WRBACK;
                end else if (r_ptr == LAST_IDX) begin
                    flush_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_ptr_inc = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_flushing <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && flush_req) begin
                r_flushing <= 1'b1;
                r_ptr      <= '0;
            end else if (r_state == ST_IDLE && cpu_req) begin
                r_we    <= cpu_we;
                r_addr  <= cpu_addr;
                r_wdata <= cpu_wdata;
            end
            if (mem_req && mem_ack)
                r_cnt <= r_cnt + 1'b1;
            if (w_ptr_inc)
                r_ptr <= r_ptr + 1'b1;
            if (flush_done)
                r_flushing <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_data_we && !reset)
            r_data[w_data_waddr] <= w_data_wval;
    end

endmodule

// File: tb/tb_l1_dcache_wb.sv
// Scoreboard bench for l1_dcache_wb: directed accesses push expected CPU
// responses, memory beats and flush pulses; a monitor pops and compares them.
module tb_l1_dcache_wb;

    localparam int K_CPU = 0;
    localparam int K_MEM = 1;
    localparam int K_FD  = 2;

    typedef struct {
        int          kind;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
        bit          chk_data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, flush_req;
    logic [15:0] cpu_addr, cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_ready, flush_done;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          stall = 0;
    logic [15:0] mem_model [bit [15:0]];

    always #5 clk = ~clk;

    l1_dcache_wb #(
        .ADDR_WIDTH  (16),
        .DATA_WIDTH  (16),
        .BLOCK_WORDS (8),
        .NUM_BLOCKS  (512)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_ready  (cpu_ready),
        .flush_req  (flush_req),
        .flush_done (flush_done),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    function automatic void exp_mem(input logic we, input logic [15:0] a, input logic [15:0] d);
        exp_t e;
        e.kind = K_MEM; e.we = we; e.addr = a; e.data = d; e.chk_data = we;
        q.push_back(e);
    endfunction

    function automatic void exp_cpu(input logic [15:0] d, input bit chk_d);
        exp_t e;
        e.kind = K_CPU; e.we = 1'b0; e.addr = '0; e.data = d; e.chk_data = chk_d;
        q.push_back(e);
    endfunction

    function automatic void exp_fd();
        exp_t e;
        e.kind = K_FD; e.we = 1'b0; e.addr = '0; e.data = '0; e.chk_data = 1'b0;
        q.push_back(e);
    endfunction

    function automatic void exp_refill(input logic [15:0] base, input logic [15:0] d0);
        for (int i = 0; i < 8; i++)
            exp_mem(1'b0, base + 16'(i), d0 + 16'(i));
    endfunction

    function automatic logic [15:0] rd_model(input logic [15:0] a);
        if (mem_model.exists(a))
            return mem_model[a];
        return 16'hA000 + {13'd0, a[2:0]};
    endfunction

    function automatic bit take(input int kind, input string name, output exp_t e);
        e.kind = -1; e.we = 1'b0; e.addr = '0; e.data = '0; e.chk_data = 1'b0;
        if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: got unexpected event, expected none", name);
            return 1'b0;
        end
        e = q.pop_front();
        chk({name, "_kind"}, kind, e.kind);
        return kind == e.kind;
    endfunction

    // Memory responder: acks after `stall` wait cycles and stores writebacks.
    initial begin
        int wcnt;
        wcnt      = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_req && !reset) begin
                if (wcnt >= stall) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rd_model(mem_addr);
                    if (mem_we)
                        mem_model[mem_addr] = mem_wdata;
                    wcnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end
        end
    end

    // Monitor: values sampled mid-low-phase are those seen by the next rising edge.
    initial begin
        exp_t        e;
        logic        pend;
        logic        p_we;
        logic [15:0] p_addr, p_wdata;
        pend = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                pend = 1'b0;
                continue;
            end
            if (mem_req && pend) begin
                chk("stall_addr_stable", mem_addr, p_addr);
                chk("stall_we_stable", mem_we, p_we);
                chk("stall_wdata_stable", mem_wdata, p_wdata);
            end
            if (mem_req && mem_ack) begin
                if (take(K_MEM, "mem_beat", e)) begin
                    chk("beat_we", mem_we, e.we);
                    chk("beat_addr", mem_addr, e.addr);
                    if (e.chk_data)
                        chk("beat_wdata", mem_wdata, e.data);
                end
            end
            pend    = mem_req && !mem_ack;
            p_we    = mem_we;
            p_addr  = mem_addr;
            p_wdata = mem_wdata;
            if (cpu_ready) begin
                if (take(K_CPU, "cpu_resp", e) && e.chk_data)
                    chk("cpu_rdata", cpu_rdata, e.data);
            end
            if (flush_done)
                void'(take(K_FD, "flush_done", e));
        end
    end

    task automatic cpu_access(input logic we, input logic [15:0] a, input logic [15:0] d,
                              input bit hit);
        int lat;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        @(negedge clk);
        cpu_req = 1'b0;
        #2;
        lat = 1;
        while (!cpu_ready && lat < 300) begin
            @(negedge clk);
            #2;
            lat++;
        end
        if (!cpu_ready)
            chk("cpu_ready_timeout", cpu_ready, 1);
        else if (hit)
            chk("hit_latency", lat, 1);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int c;
        c = 0;
        do begin
            @(negedge clk);
            #3;
            c++;
        end while (q.size() != 0 && c < budget);
        chk({name, "_drained"}, q.size(), 0);
        q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; flush_req = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_flush_done", flush_done, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(negedge clk);
        reset = 1'b0;

        // cold miss, then hit
        exp_refill(16'h1230, 16'hA000);
        exp_cpu(16'hA004, 1'b1);
        cpu_access(1'b0, 16'h1234, '0, 1'b0);
        wait_drain(20, "cold_miss");

        exp_cpu(16'hA004, 1'b1);
        cpu_access(1'b0, 16'h1234, '0, 1'b1);
        wait_drain(5, "read_hit");

        exp_cpu(16'h0000, 1'b0);
        cpu_access(1'b1, 16'h1235, 16'hBEEF, 1'b1);
        wait_drain(5, "write_hit");

        // conflict miss on a dirty block, with 3-cycle ack stalls
        stall = 3;
        for (int i = 0; i < 8; i++)
            exp_mem(1'b1, 16'h1230 + 16'(i), (i == 5) ? 16'hBEEF : 16'hA000 + 16'(i));
        exp_refill(16'h9230, 16'hA000);
        exp_cpu(16'hA004, 1'b1);
        cpu_access(1'b0, 16'h9234, '0, 1'b0);
        wait_drain(20, "dirty_evict");
        stall = 0;

        // clean evict; refill returns the written-back word
        for (int i = 0; i < 8; i++)
            exp_mem(1'b0, 16'h1230 + 16'(i), 16'h0);
        exp_cpu(16'hBEEF, 1'b1);
        cpu_access(1'b0, 16'h1235, '0, 1'b0);
        wait_drain(20, "clean_evict");

        // make idx 0x000 and 0x1FF dirty
        exp_refill(16'h0000, 16'hA000);
        exp_cpu(16'h0000, 1'b0);
        cpu_access(1'b1, 16'h0003, 16'h1111, 1'b0);
        exp_refill(16'hFFF8, 16'hA000);
        exp_cpu(16'h0000, 1'b0);
        cpu_access(1'b1, 16'hFFFA, 16'h2222, 1'b0);
        wait_drain(20, "dirty_setup");

        // flush with a simultaneous cpu_req that must be dropped
        stall = 1;
        for (int i = 0; i < 8; i++)
            exp_mem(1'b1, 16'h0000 + 16'(i), (i == 3) ? 16'h1111 : 16'hA000 + 16'(i));
        for (int i = 0; i < 8; i++)
            exp_mem(1'b1, 16'hFFF8 + 16'(i), (i == 2) ? 16'h2222 : 16'hA000 + 16'(i));
        exp_fd();
        @(negedge clk);
        flush_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h4444;
        @(negedge clk);
        flush_req = 1'b0; cpu_req = 1'b0;
        wait_drain(2000, "flush");
        repeat (5) @(negedge clk);
        stall = 0;

        // valid bits survive the flush
        exp_cpu(16'h1111, 1'b1);
        cpu_access(1'b0, 16'h0003, '0, 1'b1);
        exp_cpu(16'h2222, 1'b1);
        cpu_access(1'b0, 16'hFFFA, '0, 1'b1);
        wait_drain(5, "post_flush_hits");

        // nothing left dirty: second flush only pulses done
        exp_fd();
        @(negedge clk);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        wait_drain(1000, "empty_flush");

        // reset while refill beat index 4 is pending
        stall = 3;
        for (int i = 0; i < 4; i++)
            exp_mem(1'b0, 16'h5670 + 16'(i), 16'h0);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h5670;
        @(negedge clk);
        cpu_req = 1'b0;
        c = 0;
        while (q.size() != 0 && c < 100) begin
            @(negedge clk);
            #3;
            c++;
        end
        chk("pre_reset_beats", q.size(), 0);
        q.delete();
        @(negedge clk);
        #3;
        reset = 1'b1;
        @(negedge clk);
        #2;
        chk("mem_req_after_reset", mem_req, 0);
        @(negedge clk);
        reset = 1'b0;
        stall = 0;

        exp_refill(16'h5670, 16'hA000);
        exp_cpu(16'hA000, 1'b1);
        cpu_access(1'b0, 16'h5670, '0, 1'b0);
        wait_drain(20, "post_reset_refill");

        for (int i = 0; i < 8; i++)
            exp_mem(1'b0, 16'h0000 + 16'(i), 16'h0);
        exp_cpu(16'h1111, 1'b1);
        cpu_access(1'b0, 16'h0003, '0, 1'b0);
        wait_drain(20, "post_reset_flushed_data");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
